// File: rtl/cache_controller_if.sv
// cache_controller_if: bundles every non-clock signal of the cache controller.
//   CPU side   : cpu_valid/cpu_ready request handshake, cpu_we, cpu_addr,
//                cpu_wdata, cpu_rdata/cpu_done/cpu_err completion.
//   Cache side : c_read/c_write/c_write_line strobes, c_address, c_data_i,
//                c_line_i toward the array; c_data_o, c_hit, c_miss back.
//   Memory side: mem_req/mem_we/mem_addr/mem_wdata out, mem_rline/mem_ack in.
//   Statistics : stat_clr in, hit_cnt/miss_cnt out.
// Modports:
//   master - the controller, which masters the cache array and memory port.
//   slave  - the environment (CPU, cache array, memory) around it.
interface cache_controller_if #(
  parameter int BLOCK_SIZE             = 32,
  parameter int NUM_OF_BLOCKS_PER_LINE = 4,
  parameter int ADDRESS_SIZE           = 32
);
  localparam int LINE_W = NUM_OF_BLOCKS_PER_LINE * BLOCK_SIZE;

  logic                    cpu_valid;
  logic                    cpu_ready;
  logic                    cpu_we;
  logic [ADDRESS_SIZE-1:0] cpu_addr;
  logic [BLOCK_SIZE-1:0]   cpu_wdata;
  logic [BLOCK_SIZE-1:0]   cpu_rdata;
  logic                    cpu_done;
  logic                    cpu_err;

  logic                    c_read;
  logic                    c_write;
  logic                    c_write_line;
  logic [ADDRESS_SIZE-1:0] c_address;
  logic [BLOCK_SIZE-1:0]   c_data_i;
  logic [LINE_W-1:0]       c_line_i;
  logic [BLOCK_SIZE-1:0]   c_data_o;
  logic                    c_hit;
  logic                    c_miss;

  logic                    mem_req;
  logic                    mem_we;
  logic [ADDRESS_SIZE-1:0] mem_addr;
  logic [BLOCK_SIZE-1:0]   mem_wdata;
  logic [LINE_W-1:0]       mem_rline;
  logic                    mem_ack;

  logic                    stat_clr;
  logic [15:0]             hit_cnt;
  logic [15:0]             miss_cnt;

  modport master (
    input  cpu_valid, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ready, cpu_rdata, cpu_done, cpu_err,
    output c_read, c_write, c_write_line, c_address, c_data_i, c_line_i,
    input  c_data_o, c_hit, c_miss,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rline, mem_ack,
    input  stat_clr,
    output hit_cnt, miss_cnt
  );

  modport slave (
    output cpu_valid, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ready, cpu_rdata, cpu_done, cpu_err,
    input  c_read, c_write, c_write_line, c_address, c_data_i, c_line_i,
    output c_data_o, c_hit, c_miss,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rline, mem_ack,
    output stat_clr,
    input  hit_cnt, miss_cnt
  );
endinterface

// File: rtl/cache_controller.sv
// cache_controller: sequences single-word CPU loads/stores onto a direct-mapped
// cache array and its backing memory. Write-through, no-write-allocate; read
// misses refill a whole line. Every store is preceded by a lookup because the
// array only checks the valid bit on writes, not the tag.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   bus_if       - cache_controller_if.master (CPU, cache, memory, statistics)
//   dbg_state_o  - current FSM state, for observation only
// Handshake: a CPU request is taken in the cycle where cpu_valid & cpu_ready;
// cpu_ready is high only in IDLE. Completion is a one-cycle cpu_done pulse,
// qualified by cpu_err (memory timeout). mem_req is held until a one-cycle
// mem_ack or until MEM_TIMEOUT cycles pass without one.
module cache_controller #(
  parameter int BLOCK_SIZE             = 32,
  parameter int NUM_OF_BLOCKS_PER_LINE = 4,
  parameter int ADDRESS_SIZE           = 32,
  parameter int MEM_TIMEOUT            = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  cache_controller_if.master  bus_if,
  output logic [2:0]          dbg_state_o
);
  localparam int LINE_W = NUM_OF_BLOCKS_PER_LINE * BLOCK_SIZE;
  localparam int OFF_W  = $clog2(NUM_OF_BLOCKS_PER_LINE);
  localparam int TO_W   = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_CHECK, S_REFILL, S_FILL, S_MEMWR, S_RESP
  } state_t;

  state_t                  state_q, state_d;
  logic                    we_q, we_d;
  logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
  logic [BLOCK_SIZE-1:0]   wdata_q, wdata_d;
  logic [BLOCK_SIZE-1:0]   rdata_q, rdata_d;
  logic [LINE_W-1:0]       line_q, line_d;
  logic                    pend_q, pend_d;   // cache word write owed in MEMWR
  logic                    err_q, err_d;     // memory timed out this request
  logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
  logic [15:0]             hit_cnt_q, hit_cnt_d;
  logic [15:0]             miss_cnt_q, miss_cnt_d;
  logic                    lookup_hit;
  logic                    mem_timeout;

  assign lookup_hit  = bus_if.c_hit & ~bus_if.c_miss;
  // Last no-ack cycle: mem_req has then been high for MEM_TIMEOUT cycles.
  assign mem_timeout = (to_cnt_q == TO_W'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    line_d     = line_q;
    pend_d     = pend_q;
    err_d      = err_q;
    to_cnt_d   = to_cnt_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;

    bus_if.cpu_ready    = 1'b0;
    bus_if.cpu_done     = 1'b0;
    bus_if.cpu_err      = 1'b0;
    bus_if.c_read       = 1'b0;
    bus_if.c_write      = 1'b0;
    bus_if.c_write_line = 1'b0;
    bus_if.c_data_i     = '0;
    bus_if.c_line_i     = '0;
    bus_if.mem_req      = 1'b0;
    bus_if.mem_we       = 1'b0;
    bus_if.mem_addr     = '0;
    bus_if.mem_wdata    = '0;

    case (state_q)
      S_IDLE: begin
        bus_if.cpu_ready = 1'b1;
        if (bus_if.cpu_valid) begin
          we_d    = bus_if.cpu_we;
          addr_d  = bus_if.cpu_addr;
          wdata_d = bus_if.cpu_wdata;
          pend_d  = 1'b0;
          err_d   = 1'b0;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        bus_if.c_read = 1'b1;
        state_d       = S_CHECK;
      end
      S_CHECK: begin
        // Lookup result is registered in the array: valid only this cycle.
        to_cnt_d = '0;
        if (lookup_hit) begin
          if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
        end else begin
          if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
        end
        if (we_q) begin
          pend_d  = lookup_hit;   // only update the array if the tag matched
          state_d = S_MEMWR;
        end else if (lookup_hit) begin
          rdata_d = bus_if.c_data_o;
          state_d = S_RESP;
        end else begin
          state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        bus_if.mem_req  = 1'b1;
        bus_if.mem_addr = {addr_q[ADDRESS_SIZE-1:OFF_W], {OFF_W{1'b0}}};
        if (bus_if.mem_ack) begin
          line_d  = bus_if.mem_rline;
          state_d = S_FILL;
        end else if (mem_timeout) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_FILL: begin
        bus_if.c_write_line = 1'b1;
        bus_if.c_line_i     = line_q;
        rdata_d = line_q[int'(addr_q[OFF_W-1:0]) * BLOCK_SIZE +: BLOCK_SIZE];
        state_d = S_RESP;
      end
      S_MEMWR: begin
        bus_if.mem_req   = 1'b1;
        bus_if.mem_we    = 1'b1;
        bus_if.mem_addr  = addr_q;
        bus_if.mem_wdata = wdata_q;
        if (pend_q) begin
          bus_if.c_write  = 1'b1;
          bus_if.c_data_i = wdata_q;
          pend_d          = 1'b0;
        end
        if (bus_if.mem_ack) begin
          state_d = S_RESP;
        end else if (mem_timeout) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        bus_if.cpu_done = 1'b1;
        bus_if.cpu_err  = err_q;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Clear wins over an increment landing in the same cycle.
    if (bus_if.stat_clr) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      line_q     <= '0;
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
      to_cnt_q   <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      line_q     <= line_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
      to_cnt_q   <= to_cnt_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign bus_if.c_address = addr_q;
  assign bus_if.cpu_rdata = rdata_q;
  assign bus_if.hit_cnt   = hit_cnt_q;
  assign bus_if.miss_cnt  = miss_cnt_q;
  assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: drives CPU requests into cache_controller, emulates the
// direct-mapped cache array and a 256-word backing memory around it, and
// checks every completion against a policy-level reference model
// (write-through, no-write-allocate, allocate on read miss).
module tb_cache_controller;
  localparam int BS = 32;
  localparam int NB = 4;
  localparam int NL = 4;
  localparam int AW = 32;
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0] dbg_state;

  cache_controller_if #(.BLOCK_SIZE(BS), .NUM_OF_BLOCKS_PER_LINE(NB),
                        .ADDRESS_SIZE(AW)) bus ();

  cache_controller #(.BLOCK_SIZE(BS), .NUM_OF_BLOCKS_PER_LINE(NB),
                     .ADDRESS_SIZE(AW), .MEM_TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus_if      (bus.master),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [BS-1:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BS-1:0] init_word(input int a);
    if (a >= 4 && a <= 7) return BS'((a - 4) * 'h11);
    return BS'(a) * 32'h0100_0193 ^ 32'hC0FF_EE00;
  endfunction

  // ---------------- reference model ----------------
  logic [BS-1:0] ref_mem[256];
  bit            res_vld[NL];
  logic [AW-1:0] res_tag[NL];
  int            m_hit = 0;
  int            m_miss = 0;
  logic [BS-1:0] last_rdata = '0;

  // ---------------- environment: cache array + memory ----------------
  logic [BS-1:0] arr[NL][NB];
  bit            vld[NL];
  logic [AW-1:0] tg[NL];
  logic [BS-1:0] mem[256];
  bit            env_init = 1'b0;
  int            mem_lat = 0;
  bit            mem_never = 1'b0;
  int            mem_wait = 0;

  always @(negedge clk) begin
    bus.mem_ack <= 1'b0;
    if (!env_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      for (int l = 0; l < NL; l++) vld[l] <= 1'b0;
      bus.c_hit     <= 1'b0;
      bus.c_miss    <= 1'b0;
      bus.c_data_o  <= '0;
      bus.mem_rline <= '0;
      env_init      <= 1'b1;
    end
    if (!rst_n) begin
      mem_wait <= 0;
    end else begin
      if (bus.c_read) begin
        bus.c_hit  <= vld[bus.c_address[3:2]] && (tg[bus.c_address[3:2]] == (bus.c_address >> 4));
        bus.c_miss <= !(vld[bus.c_address[3:2]] && (tg[bus.c_address[3:2]] == (bus.c_address >> 4)));
        bus.c_data_o <= arr[bus.c_address[3:2]][bus.c_address[1:0]];
      end
      // The array checks only the valid bit on word writes.
      if (bus.c_write && vld[bus.c_address[3:2]])
        arr[bus.c_address[3:2]][bus.c_address[1:0]] <= bus.c_data_i;
      if (bus.c_write_line) begin
        for (int w = 0; w < NB; w++)
          arr[bus.c_address[3:2]][w] <= bus.c_line_i[w*BS +: BS];
        vld[bus.c_address[3:2]] <= 1'b1;
        tg[bus.c_address[3:2]]  <= bus.c_address >> 4;
      end
      if (bus.mem_req) begin
        if (!mem_never && mem_wait >= mem_lat) begin
          bus.mem_ack <= 1'b1;
          mem_wait    <= 0;
          if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
          else
            for (int w = 0; w < NB; w++)
              bus.mem_rline[w*BS +: BS] <= mem[8'(bus.mem_addr[7:0] + 8'(w))];
        end else begin
          mem_wait <= mem_wait + 1;
        end
      end else begin
        mem_wait <= 0;
      end
    end
  end

  // ---------------- driver: one CPU transaction ----------------
  task automatic do_req(input bit we, input logic [AW-1:0] addr,
                        input logic [BS-1:0] wd, input bit clr);
    int            idx, t0, rc, guard;
    bit            exp_hit, exp_to, done;
    int            n_rd, rd_rc, n_cw, cw_rc, n_wl, n_mr, mr_first, done_rc;
    logic          mr_we, got_err;
    logic [AW-1:0] mr_addr;
    logic [BS-1:0] mr_wd, cw_data, got_rdata, exp_rd;
    logic [15:0]   got_hc, got_mc;

    idx     = int'(addr[3:2]);
    exp_hit = res_vld[idx] && (res_tag[idx] == (addr >> 4));
    exp_to  = mem_never && !(!we && exp_hit);
    n_rd = 0; rd_rc = -1; n_cw = 0; cw_rc = -1; n_wl = 0; n_mr = 0;
    mr_first = -1; done_rc = -1; done = 1'b0;
    mr_we = 1'b0; mr_addr = '0; mr_wd = '0; cw_data = '0;
    got_rdata = '0; got_err = 1'b0; got_hc = '0; got_mc = '0;

    guard = 0;
    while (!bus.cpu_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("ready_bound", bus.cpu_ready, 1);

    if (!we) exp_q.push_back(exp_to ? last_rdata : ref_mem[addr[7:0]]);
    bus.cpu_valid = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    t0 = cyc;
    @(negedge clk);
    bus.cpu_valid = 1'b0;

    for (int k = 0; k < 400 && !done; k++) begin
      rc = cyc - t0;
      bus.stat_clr = clr && (rc == 2);
      if (bus.c_read) begin n_rd++; rd_rc = rc; end
      if (bus.c_write) begin n_cw++; cw_rc = rc; cw_data = bus.c_data_i; end
      if (bus.c_write_line) n_wl++;
      if (bus.mem_req) begin
        n_mr++;
        if (mr_first < 0) begin
          mr_first = rc; mr_we = bus.mem_we;
          mr_addr = bus.mem_addr; mr_wd = bus.mem_wdata;
        end
      end
      if (bus.cpu_done) begin
        done = 1'b1; done_rc = rc; got_rdata = bus.cpu_rdata;
        got_err = bus.cpu_err; got_hc = bus.hit_cnt; got_mc = bus.miss_cnt;
      end else begin
        @(negedge clk);
      end
    end
    bus.stat_clr = 1'b0;
    if (!done) begin
      $display("FAIL done_bound: no cpu_done for addr %0h, state %0d", addr, dbg_state);
      check("done_bound", 0, 1);
      void'(exp_q.pop_back());
      return;
    end

    // Reference statistics.
    if (clr) begin
      m_hit = 0; m_miss = 0;
    end else if (exp_hit) begin
      if (m_hit < 65535) m_hit++;
    end else begin
      if (m_miss < 65535) m_miss++;
    end

    check("c_read_cnt", n_rd, 1);
    check("c_read_at", rd_rc, 1);
    check("hit_cnt", got_hc, m_hit);
    check("miss_cnt", got_mc, m_miss);
    check("cpu_err", got_err, exp_to);
    check("c_write_cnt", n_cw, (we && exp_hit) ? 1 : 0);
    if (we && exp_hit) begin
      check("c_write_at", cw_rc, 3);
      check("c_write_data", cw_data, wd);
    end
    check("c_write_line_cnt", n_wl, (!we && !exp_hit && !exp_to) ? 1 : 0);

    if (!we && exp_hit) begin
      check("done_at_hit", done_rc, 3);
      check("mem_req_cnt_hit", n_mr, 0);
    end else begin
      check("mem_req_first", mr_first, 3);
      check("mem_we", mr_we, we);
      check("mem_addr", mr_addr, we ? addr : (addr & ~32'h3));
      if (we) check("mem_wdata", mr_wd, wd);
      check("mem_req_cnt", n_mr, exp_to ? TO : mem_lat + 1);
      check("done_at", done_rc, exp_to ? 3 + TO : (we ? 3 + mem_lat + 1 : 3 + mem_lat + 2));
    end

    if (!we) begin
      exp_rd = exp_q.pop_front();
      check("cpu_rdata", got_rdata, exp_rd);
      last_rdata = exp_rd;
    end

    if (we && !exp_to) ref_mem[addr[7:0]] = wd;
    if (!we && !exp_hit && !exp_to) begin
      res_vld[idx] = 1'b1;
      res_tag[idx] = addr >> 4;
    end

    @(negedge clk);
    check("ready_after", bus.cpu_ready, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int guard;
    bus.cpu_valid = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.stat_clr  = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    for (int l = 0; l < NL; l++) res_vld[l] = 1'b0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_strobes", {bus.cpu_done, bus.cpu_err, bus.c_read, bus.c_write,
                            bus.c_write_line, bus.mem_req, bus.mem_we}, 0);
    check("reset_ready", bus.cpu_ready, 1);
    check("reset_counters", {bus.hit_cnt, bus.miss_cnt}, 0);
    check("reset_rdata", bus.cpu_rdata, 0);
    check("reset_addr", {bus.c_address, bus.mem_addr}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Cold read miss, memory acks after 4 cycles.
    mem_lat = 4;
    do_req(1'b0, 32'h6, '0, 1'b0);
    // Write hit then read hit of the same word.
    mem_lat = 1;
    do_req(1'b1, 32'h5, 32'hDEAD_BEEF, 1'b0);
    do_req(1'b0, 32'h5, '0, 1'b0);
    // Write hit, write with tag mismatch, re-read.
    mem_lat = 2;
    do_req(1'b1, 32'h6, 32'hA5, 1'b0);
    do_req(1'b1, 32'h46, 32'h5A, 1'b0);
    do_req(1'b0, 32'h6, '0, 1'b0);
    // Memory never answers a refill.
    mem_never = 1'b1;
    do_req(1'b0, 32'h80, '0, 1'b0);
    mem_never = 1'b0;

    // Reset while a refill is outstanding.
    mem_never = 1'b1;
    bus.cpu_valid = 1'b1;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 32'h90;
    @(negedge clk);
    bus.cpu_valid = 1'b0;
    guard = 0;
    while (!bus.mem_req && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("abort_reached_refill", bus.mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_async_outs", {bus.mem_req, bus.cpu_done, bus.c_write_line}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mem_never = 1'b0;
    m_hit = 0; m_miss = 0; last_rdata = '0;
    @(negedge clk);
    check("abort_ready", bus.cpu_ready, 1);
    check("abort_counters", {bus.hit_cnt, bus.miss_cnt}, 0);
    check("abort_rdata", bus.cpu_rdata, 0);
    do_req(1'b0, 32'h90, '0, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      mem_lat = $urandom_range(0, 5);
      do_req(1'(($urandom_range(0, 1))), 32'($urandom_range(0, 255)), $urandom, 1'b0);
    end

    // Saturation and clear of the hit counter.
    mem_lat = 1;
    do_req(1'b0, 32'h6, '0, 1'b0);
    force dut.hit_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.hit_cnt_q;
    m_hit = 65534;
    do_req(1'b0, 32'h6, '0, 1'b0);
    do_req(1'b0, 32'h6, '0, 1'b0);
    do_req(1'b0, 32'h6, '0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit, state %0d", dbg_state);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cache_controller.md
# cache_controller

Sequencing controller for the direct-mapped cache array: accepts single-word CPU read/write requests, drives the array's read/write/write_line strobes, refills lines from memory on read miss, and writes through every store to memory. Sits between the CPU load/store port and the direct-mapped cache plus its backing memory. Policy: write-through, no-write-allocate. Tag checking is done by a lookup before every write, because the array itself only checks the valid bit on writes.

## Interface
- BLOCK_SIZE, 32, bits per word/block
- NUM_OF_BLOCKS_PER_LINE, 4, words per line (power of 2)
- NUM_OF_CACHE_LINES, 4, lines in array (power of 2)
- ADDRESS_SIZE, 32, word-address width
- MEM_TIMEOUT, 255, max cycles mem_req is held without mem_ack (≥1)
- Derived: LINE_W = NUM_OF_BLOCKS_PER_LINE*BLOCK_SIZE; OFF_W = $clog2(NUM_OF_BLOCKS_PER_LINE)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- cpu_valid  in  1  request present
- cpu_ready  out  1  controller idle; request accepted when cpu_valid & cpu_ready
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDRESS_SIZE  word address
- cpu_wdata  in  BLOCK_SIZE  write data
- cpu_rdata  out  BLOCK_SIZE  read data, valid with cpu_done
- cpu_done  out  1  one-cycle completion pulse
- cpu_err  out  1  qualifies cpu_done; 1 = memory timeout
- c_read, c_write, c_write_line  out  1 each  cache strobes, one-cycle pulses
- c_address  out  ADDRESS_SIZE  cache address (latched request address)
- c_data_i  out  BLOCK_SIZE  cache write word
- c_line_i  out  LINE_W  cache refill line
- c_data_o  in  BLOCK_SIZE  cache read word (registered in cache)
- c_hit, c_miss  in  1 each  cache lookup result (registered in cache, sticky)
- mem_req  out  1  memory request, held until mem_ack or timeout
- mem_we  out  1  1 = word write, 0 = line read
- mem_addr  out  ADDRESS_SIZE  line-aligned (offset bits zero) for reads; full word address for writes
- mem_wdata  out  BLOCK_SIZE  write word
- mem_rline  in  LINE_W  refill line, valid with mem_ack
- mem_ack  in  1  one-cycle completion; ignored while mem_req = 0
- stat_clr  in  1  synchronous clear of counters
- hit_cnt, miss_cnt  out  16 each  saturating lookup statistics

## Operation
- States: IDLE, LOOKUP, CHECK, REFILL, FILL, MEMWR, RESP.
- IDLE: cpu_ready = 1 (combinational from state). On accept, latch cpu_we, cpu_addr, and cpu_wdata, then go to LOOKUP.
- LOOKUP: c_read = 1 for one cycle, then go to CHECK.
- CHECK: sample c_hit/c_miss, which are only meaningful in this cycle. Increment hit_cnt or miss_cnt, saturating at 0xFFFF.
  - read hit: register cpu_rdata <= c_data_o, then go to RESP.
  - read miss: go to REFILL.
  - write hit: set a pending c_write flag, then go to MEMWR.
  - write miss: go to MEMWR with no cache update.
- REFILL: mem_req = 1, mem_we = 0, mem_addr = {addr[ADDRESS_SIZE-1:OFF_W], OFF_W'b0}.
  - On mem_ack: latch mem_rline, then go to FILL.
- FILL: c_write_line = 1 and c_line_i = latched line.
  - cpu_rdata <= latched_line[offset*BLOCK_SIZE +: BLOCK_SIZE]; block 0 occupies the LSBs.
  - Then go to RESP.
- MEMWR: mem_req = 1, mem_we = 1, mem_addr = addr, mem_wdata = wdata.
  - If the pending flag is set, c_write = 1 and c_data_i = wdata in the first MEMWR cycle only.
  - On mem_ack, go to RESP.
- RESP: cpu_done = 1 for one cycle. cpu_err reflects the timeout flag. Then go to IDLE.
- Timeout: the counter resets on entering REFILL/MEMWR and counts cycles with mem_req = 1 and no ack.
  - When the count reaches MEM_TIMEOUT, drop mem_req and set the error flag.
  - Go to RESP with cpu_rdata unchanged.
  - No c_write_line. A c_write already pulsed on a write hit stands, since the cache is ahead of memory.
- mem_ack is accepted in any cycle with mem_req = 1, including the first.
- stat_clr has priority over an increment in the same cycle.
- Outputs not named active in a state are 0. c_address always equals the latched address.

## Timing
- Reset (async assert, sync deassert via clk):
  - State is IDLE and cpu_ready = 1.
  - All other outputs are 0, including counters, cpu_rdata, and the strobes.
- Reset mid-operation: abort immediately, with no strobe or mem_req glitch after assertion. Any outstanding memory transaction is abandoned.
- Read hit: accept at T, c_read at T+1, CHECK at T+2, cpu_done at T+3.
- Read miss: mem_req from T+3. With mem_ack at cycle A, c_write_line is at A+1 and cpu_done at A+2.
- Write: mem_req from T+3 (c_write also at T+3 on hit). With mem_ack at A, cpu_done is at A+1.
- Timeout: mem_req high for exactly MEM_TIMEOUT cycles, then cpu_done with cpu_err = 1 one cycle later.
- Throughput: the next accept is possible in the cycle after cpu_done (IDLE).

## Test plan
- Read hit: preload line 1 (tag 0) via refill, then read addr 0x5 with word 1 = 0xDEADBEEF.
  - Required: c_read at T+1, cpu_done at T+3 with cpu_rdata = 0xDEADBEEF, hit_cnt = 1.
- Read miss: cold cache, read 0x6; memory acks after 4 cycles with line {0x33,0x22,0x11,0x00}.
  - Required: mem_addr = 0x4 and mem_we = 0.
  - Required: c_write_line one cycle after ack, cpu_rdata = 0x22, miss_cnt = 1.
- Write hit then miss: write 0x6 ← 0xA5 (line resident), then write 0x46 ← 0x5A (tag mismatch).
  - Required for both: mem_we = 1 with correct address/data.
  - Required: c_write only for the first; re-reading 0x6 gives 0xA5.
- Timeout: MEM_TIMEOUT = 8, memory never acks on a read miss.
  - Required: mem_req high exactly 8 cycles, then cpu_done with cpu_err = 1, no c_write_line, back in IDLE.
- Reset mid-refill: assert rst_n low while in REFILL.
  - Required: mem_req and cpu_done are 0 asynchronously, cpu_ready = 1 after release, counters are 0.
  - Required: a subsequent read completes normally.
- Counter saturation/clear: force 0x10000 hits, then assert stat_clr coincident with a hit.
  - Required: hit_cnt holds at 0xFFFF, then reads 0.
